// File: rtl/block_forward_quantisation_pkg.sv
// Shared definitions for the block forward quantiser.
//  - Coefficient-buffer word codes written to the decode path.
//  - Quant_Scan_ROM image and regions: scan tables, then weight matrices.
//  - FSM state encoding.
//  - Quantiser-scale mapping helper.
package block_forward_quantisation_pkg;

  // Fixed cycles per scan position: 3 fetch + 17 divide + 1 emit.
  localparam int CYC_PER_POS = 21;
  localparam int DIV_ITER    = CYC_PER_POS - 4;

  localparam logic [13:0] INFO_BLOCK_CODE     = 14'h0010;
  localparam logic [13:0] INFO_BLOCK_CODE_EOB = 14'h0011;

  // Quant_Scan_ROM region numbers (address bits [10:6]).
  localparam logic [4:0] ROM_OFS_ZIGZAG      = 5'd0;
  localparam logic [4:0] ROM_OFS_ALTERNATE   = 5'd1;
  localparam logic [4:0] ROM_OFS_INTRA_DEF   = 5'd2;
  localparam logic [4:0] ROM_OFS_NINTRA_DEF  = 5'd3;
  localparam logic [4:0] ROM_OFS_INTRA_LD    = 5'd4;
  localparam logic [4:0] ROM_OFS_NINTRA_LD   = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_FETCH3 = 3'd3,
    ST_DIVIDE = 3'd4,
    ST_EMIT   = 3'd5,
    ST_EOB    = 3'd6
  } state_e;

  // Scan position -> raster address.
  localparam int SCAN_ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  localparam int SCAN_ALT [64] = '{
     0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
    41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
    51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
    53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63};

  // Default intra weighting matrix, raster order.
  localparam int W_INTRA [64] = '{
     8, 16, 19, 22, 26, 27, 29, 34,
    16, 16, 22, 24, 27, 29, 34, 37,
    19, 22, 26, 27, 29, 34, 34, 38,
    22, 22, 26, 27, 29, 34, 37, 40,
    22, 26, 27, 29, 32, 35, 40, 48,
    26, 27, 29, 32, 35, 40, 48, 58,
    26, 27, 29, 34, 38, 46, 56, 69,
    27, 29, 35, 38, 46, 56, 69, 83};

  // ROM image. The loaded-matrix regions carry the default matrices in
  // this image; a sequence-level matrix load rewrites them elsewhere.
  function automatic logic [7:0] quant_scan_rom(input logic [10:0] addr);
    logic [7:0] d;
    d = '0;
    case (addr[10:6])
      ROM_OFS_ZIGZAG:                        d = 8'(SCAN_ZZ[addr[5:0]]);
      ROM_OFS_ALTERNATE:                     d = 8'(SCAN_ALT[addr[5:0]]);
      ROM_OFS_INTRA_DEF, ROM_OFS_INTRA_LD:   d = 8'(W_INTRA[addr[5:0]]);
      ROM_OFS_NINTRA_DEF, ROM_OFS_NINTRA_LD: d = 8'd16;
      default:                               d = '0;
    endcase
    return d;
  endfunction

  // quantiser_scale from quantiser_scale_code; result 0..112.
  function automatic logic [6:0] quant_scale(input logic nonlin, input logic [4:0] code);
    logic [7:0] c;
    c = {3'b000, code};
    if (!nonlin)           return 7'(c << 1);
    else if (code <= 5'd8)  return 7'(c);
    else if (code <= 5'd16) return 7'((c << 1) - 8'd8);
    else if (code <= 5'd24) return 7'((c << 2) - 8'd40);
    else                    return 7'((c << 3) - 8'd136);
  endfunction

endpackage

// File: rtl/block_forward_quantisation_serial_divider_u17.sv
// serial_divider_u17: restoring unsigned divider, 17-bit dividend by
// 16-bit divisor, 17-bit quotient, one quotient bit per cycle.
//  clk_i, rst_ni     clock, asynchronous active-low reset
//  start_i           load operands (first iteration is done on the load edge)
//  dividend_i[16:0]  dividend
//  divisor_i[15:0]   divisor (0 yields an all-ones quotient)
//  done_o            high from the cycle after the last iteration until next start
//  quotient_o[16:0]  quotient, valid while done_o is high
module serial_divider_u17
  import block_forward_quantisation_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [16:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        done_o,
  output logic [16:0] quotient_o
);

  logic [15:0] rem_q;
  logic [16:0] quot_q;
  logic [15:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  // One restoring step. The dividend is shifted out of the top of the
  // quotient register while quotient bits enter at the bottom. The
  // remainder always stays below the divisor, so 16 bits hold it.
  function automatic logic [32:0] div_step(input logic [15:0] rem,
                                           input logic [16:0] q,
                                           input logic [15:0] d);
    logic [16:0] t;
    logic [16:0] r;
    logic        ge;
    t  = {rem, q[16]};
    ge = (t >= {1'b0, d});
    r  = ge ? (t - {1'b0, d}) : t;
    return {r[15:0], q[15:0], ge};
  endfunction

  logic [32:0] step_first_d;
  logic [32:0] step_next_d;

  assign step_first_d = div_step(16'd0, dividend_i, divisor_i);
  assign step_next_d  = div_step(rem_q, quot_q, dvs_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      {rem_q, quot_q} <= step_first_d;
      dvs_q  <= divisor_i;
      cnt_q  <= 5'd1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      {rem_q, quot_q} <= step_next_d;
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'(DIV_ITER - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quot_q;

endmodule

// File: rtl/block_forward_quantisation.sv
// block_forward_quantisation: reads one 8x8 block of DCT coefficients,
// quantises them in scan order and writes run/level words plus EOB as
// {code[31:18], run[17:12], level[11:0]}.
//  clock, resetn              clock, asynchronous active-low reset
//  Start_Quantisation_I       start pulse, accepted only when idle
//  Done_Quantisation_O        high while idle
//  Macroblock_Intra_I         intra block
//  Intra_DC_Precision_I[1:0]  intra DC precision
//  Quant_Scale_Type_I         0 linear, 1 non-linear quantiser scale
//  Quant_Scale_Code_I[4:0]    quantiser_scale_code
//  Alternate_Scan_I           0 zigzag, 1 alternate scan
//  Load_Seq_Intra_Quant_I     select loaded intra matrix
//  Load_Seq_NIntra_Quant_I    select loaded non-intra matrix
//  Block_Read_Address_O[5:0]  raster address into block RAM (1-cycle read)
//  Block_Read_Data_I[11:0]    signed coefficient
//  Coeff_Write_En_O           write strobe
//  Coeff_Buffer_Data_O[31:0]  output word
// Every scan position takes exactly 21 cycles: FETCH1..3, 17 DIVIDE, EMIT.
// Configuration inputs are captured on Start and held for the block.
module block_forward_quantisation
  import block_forward_quantisation_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_Quantisation_I,
  output logic        Done_Quantisation_O,
  input  logic        Macroblock_Intra_I,
  input  logic [1:0]  Intra_DC_Precision_I,
  input  logic        Quant_Scale_Type_I,
  input  logic [4:0]  Quant_Scale_Code_I,
  input  logic        Alternate_Scan_I,
  input  logic        Load_Seq_Intra_Quant_I,
  input  logic        Load_Seq_NIntra_Quant_I,
  output logic [5:0]  Block_Read_Address_O,
  input  logic [11:0] Block_Read_Data_I,
  output logic        Coeff_Write_En_O,
  output logic [31:0] Coeff_Buffer_Data_O
);

  state_e      state_q;
  logic [5:0]  pos_q;
  logic [5:0]  run_q;
  logic        coded_q;
  logic        intra_q;
  logic [1:0]  idp_q;
  logic [6:0]  qs_q;
  logic        alt_q;
  logic        ld_intra_q;
  logic        ld_nintra_q;
  logic [7:0]  rom_q;
  logic [5:0]  raddr_q;
  logic        f_neg_q;
  logic        f_zero_q;
  logic        done_q;
  logic        we_q;
  logic [31:0] data_q;

  logic [10:0]        rom_addr_d;
  logic [4:0]         wofs_d;
  logic signed [11:0] f_d;
  logic [11:0]        f_abs_d;
  logic [14:0]        p_d;
  logic [16:0]        dividend_d;
  logic [15:0]        divisor_d;
  logic               div_start_d;
  logic               div_done;
  logic [16:0]        div_quot;
  logic [11:0]        level_d;
  logic               force_empty_d;
  logic               emit_word_d;
  logic [5:0]         run_field_d;

  // Saturate |QF| to 2047 and restore the sign of F as 12-bit two's complement.
  function automatic logic [11:0] sat_level(input logic [16:0] q,
                                            input logic        neg,
                                            input logic        zero);
    logic [11:0] m;
    m = (q > 17'd2047) ? 12'd2047 : q[11:0];
    if (zero) return 12'd0;
    return neg ? (~m + 12'd1) : m;
  endfunction

  // Weight matrix region: intra 4/2, non-intra 5/3 (loaded/default).
  always_comb begin
    wofs_d = ROM_OFS_NINTRA_DEF;
    if (intra_q) wofs_d = ld_intra_q  ? ROM_OFS_INTRA_LD  : ROM_OFS_INTRA_DEF;
    else         wofs_d = ld_nintra_q ? ROM_OFS_NINTRA_LD : ROM_OFS_NINTRA_DEF;
  end

  // FETCH1 looks up the raster address; FETCH2 uses it for the weight.
  always_comb begin
    rom_addr_d = '0;
    case (state_q)
      ST_FETCH1: rom_addr_d = {4'h0, alt_q, pos_q};
      ST_FETCH2: rom_addr_d = {wofs_d, rom_q[5:0]};
      default:   rom_addr_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) rom_q <= '0;
    else         rom_q <= quant_scan_rom(rom_addr_d);
  end

  // The raster address is only known from the scan ROM output during
  // FETCH2, so it is presented directly then and held afterwards.
  assign Block_Read_Address_O = (state_q == ST_FETCH2) ? rom_q[5:0] : raddr_q;

  // Operands, valid in FETCH3 when F (block RAM) and W (rom_q) arrive.
  always_comb begin
    f_d     = signed'(Block_Read_Data_I);
    f_abs_d = f_d[11] ? 12'(-f_d) : 12'(f_d);
    if (intra_q && (pos_q == 6'd0)) p_d = 15'(8'd128 >> idp_q);
    else                            p_d = {7'd0, rom_q} * {8'd0, qs_q};
    // Intra rounds to nearest by adding P before dividing by 2P.
    dividend_d  = {f_abs_d, 5'd0} + (intra_q ? {2'd0, p_d} : 17'd0);
    divisor_d   = {p_d, 1'b0};
    div_start_d = (state_q == ST_FETCH3);
  end

  serial_divider_u17 u_div (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .start_i    (div_start_d),
    .dividend_i (dividend_d),
    .divisor_i  (divisor_d),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // Emission decision. Intra DC is always coded; a block that reaches
  // position 63 without any word gets a forced {code, 0, 0} word so the
  // decoder always sees at least one coefficient before EOB.
  always_comb begin
    level_d       = sat_level(div_quot, f_neg_q, f_zero_q);
    force_empty_d = (pos_q == 6'd63) && !coded_q;
    emit_word_d   = (intra_q && (pos_q == 6'd0)) || (level_d != 12'd0) || force_empty_d;
    run_field_d   = (force_empty_d && (level_d == 12'd0)) ? 6'd0 : run_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      run_q       <= '0;
      coded_q     <= 1'b0;
      intra_q     <= 1'b0;
      idp_q       <= '0;
      qs_q        <= '0;
      alt_q       <= 1'b0;
      ld_intra_q  <= 1'b0;
      ld_nintra_q <= 1'b0;
      raddr_q     <= '0;
      f_neg_q     <= 1'b0;
      f_zero_q    <= 1'b0;
      done_q      <= 1'b1;
      we_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_Quantisation_I) begin
            state_q     <= ST_FETCH1;
            done_q      <= 1'b0;
            pos_q       <= '0;
            run_q       <= '0;
            coded_q     <= 1'b0;
            intra_q     <= Macroblock_Intra_I;
            idp_q       <= Intra_DC_Precision_I;
            qs_q        <= quant_scale(Quant_Scale_Type_I, Quant_Scale_Code_I);
            alt_q       <= Alternate_Scan_I;
            ld_intra_q  <= Load_Seq_Intra_Quant_I;
            ld_nintra_q <= Load_Seq_NIntra_Quant_I;
          end
        end
        ST_FETCH1: state_q <= ST_FETCH2;
        ST_FETCH2: begin
          raddr_q <= rom_q[5:0];
          state_q <= ST_FETCH3;
        end
        ST_FETCH3: begin
          f_neg_q  <= f_d[11];
          f_zero_q <= (f_d == 12'sd0);
          state_q  <= ST_DIVIDE;
        end
        ST_DIVIDE: begin
          if (div_done) begin
            state_q <= ST_EMIT;
            if (emit_word_d) begin
              we_q    <= 1'b1;
              data_q  <= {INFO_BLOCK_CODE, run_field_d, level_d};
              run_q   <= '0;
              coded_q <= 1'b1;
            end else begin
              run_q <= run_q + 6'd1;
            end
          end
        end
        ST_EMIT: begin
          if (pos_q == 6'd63) begin
            state_q <= ST_EOB;
            we_q    <= 1'b1;
            data_q  <= {INFO_BLOCK_CODE_EOB, 6'd0, 12'd0};
          end else begin
            state_q <= ST_FETCH1;
            pos_q   <= pos_q + 6'd1;
            we_q    <= 1'b0;
          end
        end
        ST_EOB: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Done_Quantisation_O = done_q;
  assign Coeff_Write_En_O    = we_q;
  assign Coeff_Buffer_Data_O = data_q;

endmodule

// File: tb/tb_block_forward_quantisation.sv
module tb_block_forward_quantisation;
  import block_forward_quantisation_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        intra = 1'b0;
  logic [1:0]  idp = 2'd0;
  logic        qtype = 1'b0;
  logic [4:0]  qcode = 5'd0;
  logic        alt = 1'b0;
  logic        ldi = 1'b0;
  logic        ldn = 1'b0;
  logic [5:0]  raddr;
  logic [11:0] rdata = 12'd0;
  logic        we;
  logic        done;
  logic [31:0] cdata;

  logic signed [11:0] mem [64];
  int pc = 0;
  int base = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done_cyc = -1;
  logic [31:0] wq [$];
  int          cq [$];

  localparam logic [31:0] EOBW = {INFO_BLOCK_CODE_EOB, 18'd0};

  block_forward_quantisation dut (
    .clock                   (clock),
    .resetn                  (resetn),
    .Start_Quantisation_I    (start),
    .Done_Quantisation_O     (done),
    .Macroblock_Intra_I      (intra),
    .Intra_DC_Precision_I    (idp),
    .Quant_Scale_Type_I      (qtype),
    .Quant_Scale_Code_I      (qcode),
    .Alternate_Scan_I        (alt),
    .Load_Seq_Intra_Quant_I  (ldi),
    .Load_Seq_NIntra_Quant_I (ldn),
    .Block_Read_Address_O    (raddr),
    .Block_Read_Data_I       (rdata),
    .Coeff_Write_En_O        (we),
    .Coeff_Buffer_Data_O     (cdata)
  );

  always #5 clock = ~clock;

  // Block RAM with one-cycle read latency, plus a free-running edge count.
  always @(posedge clock) begin
    pc    <= pc + 1;
    rdata <= mem[raddr];
  end

  // Write log with cycle numbers relative to the Start edge (cycle 0).
  always @(negedge clock) begin
    if (we) begin
      wq.push_back(cdata);
      cq.push_back(pc - base);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input int run, input int lvl);
    return {INFO_BLOCK_CODE, 6'(run), 12'(lvl)};
  endfunction

  function automatic logic [31:0] wget(input int i);
    if (i < wq.size()) return wq[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int cget(input int i);
    if (i < cq.size()) return cq[i];
    return -1;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 12'sd0;
  endtask

  task automatic start_block(input logic i_intra, input logic [1:0] i_idp, input logic i_type,
                             input logic [4:0] i_code, input logic i_alt);
    intra = i_intra;
    idp   = i_idp;
    qtype = i_type;
    qcode = i_code;
    alt   = i_alt;
    wq.delete();
    cq.delete();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base = pc - 1;
  endtask

  task automatic wait_done();
    done_cyc = -1;
    for (int k = 0; k < 1500; k++) begin
      if (done) begin
        done_cyc = pc - base;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_block(input logic i_intra, input logic [1:0] i_idp, input logic i_type,
                           input logic [4:0] i_code, input logic i_alt);
    start_block(i_intra, i_idp, i_type, i_code, i_alt);
    wait_done();
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clock);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", 32'(raddr), 32'd0);
    chk("rst_data", cdata, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // T1: intra DC, P=128: (32768+128)/256 = 128
    mem[0] = 12'sd1024;
    run_block(1'b1, 2'd0, 1'b0, 5'd4, 1'b0);
    chk("t1_n", wq.size(), 32'd2);
    chk("t1_w0", wget(0), wr(0, 128));
    chk("t1_c0", cget(0), 32'd21);
    chk("t1_w1", wget(1), EOBW);
    chk("t1_c1", cget(1), 32'd1345);
    chk("t1_done", done_cyc, 32'd1346);

    // T2: non-intra, W=16 qs=4, P=64: 3200/128 = 25 at scan 1
    clear_mem();
    mem[1] = 12'sd100;
    run_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    chk("t2_n", wq.size(), 32'd2);
    chk("t2_w0", wget(0), wr(1, 25));
    chk("t2_c0", cget(0), 32'd42);

    // Non-linear code 9 -> qs 10, P=160: 3200/320 = 10
    clear_mem();
    mem[0] = 12'sd100;
    run_block(1'b0, 2'd0, 1'b1, 5'd9, 1'b0);
    chk("t2_nl_w0", wget(0), wr(0, 10));

    // T3: raster 8 is scan 1 (alternate) / scan 2 (zigzag)
    clear_mem();
    mem[8] = 12'sd100;
    run_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b1);
    chk("t3_alt_w0", wget(0), wr(1, 25));
    run_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    chk("t3_zz_w0", wget(0), wr(2, 25));

    // T4: scans 0, 5 (raster 2, negative), 63
    clear_mem();
    mem[0]  = 12'sd100;
    mem[2]  = -12'sd100;
    mem[63] = 12'sd100;
    run_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    chk("t4_n", wq.size(), 32'd4);
    chk("t4_w0", wget(0), wr(0, 25));
    chk("t4_w1", wget(1), wr(4, -25));
    chk("t4_w2", wget(2), wr(57, 25));
    chk("t4_c2", cget(2), 32'd1344);
    chk("t4_w3", wget(3), EOBW);

    // All-zero non-intra block
    clear_mem();
    run_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    chk("t4z_n", wq.size(), 32'd2);
    chk("t4z_w0", wget(0), wr(0, 0));
    chk("t4z_w1", wget(1), EOBW);

    // T5: intra idp=3, P=16, saturation both ways
    clear_mem();
    mem[0] = -12'sd2048;
    run_block(1'b1, 2'd3, 1'b0, 5'd4, 1'b0);
    chk("t5_neg_w0", wget(0), {INFO_BLOCK_CODE, 6'd0, 12'h801});
    mem[0] = 12'sd2047;
    run_block(1'b1, 2'd3, 1'b0, 5'd4, 1'b0);
    chk("t5_pos_w0", wget(0), {INFO_BLOCK_CODE, 6'd0, 12'h7FF});

    // Intra zero DC still coded; scan 1 W=16 qs=8: (3200+128)/256 = 13
    clear_mem();
    mem[1] = 12'sd100;
    run_block(1'b1, 2'd0, 1'b0, 5'd4, 1'b0);
    chk("t5dc_n", wq.size(), 32'd3);
    chk("t5dc_w0", wget(0), wr(0, 0));
    chk("t5dc_w1", wget(1), wr(0, 13));

    // T6: Start while busy is ignored
    clear_mem();
    mem[1] = 12'sd100;
    start_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    repeat (200) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    chk("t6_busy_n", wq.size(), 32'd2);
    chk("t6_busy_c1", cget(1), 32'd1345);
    chk("t6_busy_done", done_cyc, 32'd1346);

    // Reset at cycle 500 aborts the block
    start_block(1'b0, 2'd0, 1'b0, 5'd2, 1'b0);
    for (int k = 0; k < 600 && (pc - base) < 500; k++) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("t6_rst_done", 32'(done), 32'd1);
    chk("t6_rst_we", 32'(we), 32'd0);
    chk("t6_rst_data", cdata, 32'd0);
    chk("t6_rst_addr", 32'(raddr), 32'd0);
    chk("t6_pre_n", wq.size(), 32'd1);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (1400) @(negedge clock);
    chk("t6_post_n", wq.size(), 32'd1);
    chk("t6_post_done", 32'(done), 32'd1);

    // Clean block after the abort
    clear_mem();
    mem[0] = 12'sd1024;
    run_block(1'b1, 2'd0, 1'b0, 5'd4, 1'b0);
    chk("t6_clean_w0", wget(0), wr(0, 128));
    chk("t6_clean_c1", cget(1), 32'd1345);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
